// File: rtl/fft_pkg.sv
// fft_pkg
// Shared constants and helpers for the Q16.16 datapath blocks.
//   DATA_W   - operand/result width (Q16.16)
//   FRAC_W   - number of fractional bits
//   NUM_REQ  - requesters sharing the multiplier
//   MULT_LAT - cycles from grant to result
package fft_pkg;

  localparam int DATA_W   = 32;
  localparam int FRAC_W   = 16;
  localparam int NUM_REQ  = 4;
  localparam int MULT_LAT = 2;
  localparam int TAG_W    = $clog2(NUM_REQ);

  typedef logic [DATA_W-1:0]  q16_t;
  typedef logic [TAG_W-1:0]   tag_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  // Full-precision signed product, then keep the Q16.16 window [47:16].
  // Dropping the low bits of a two's-complement value floors toward
  // minus infinity; dropping the high bits wraps on overflow.
  function automatic q16_t q16_mul(input q16_t a, input q16_t b);
    logic signed [2*DATA_W-1:0] ext_a;
    logic signed [2*DATA_W-1:0] ext_b;
    logic signed [2*DATA_W-1:0] full;
    ext_a = {{DATA_W{a[DATA_W-1]}}, a};
    ext_b = {{DATA_W{b[DATA_W-1]}}, b};
    full  = ext_a * ext_b;
    return full[FRAC_W +: DATA_W];
  endfunction

  function automatic req_vec_t tag_to_onehot(input tag_t t);
    req_vec_t oh;
    oh    = '0;
    oh[t] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mult_q16_pipe.sv
// mult_q16_pipe
// Two-stage signed Q16.16 multiplier with a valid/tag sideband that travels
// alongside the data.
//   clk, rst           - clock, synchronous active-high reset
//   in_valid/in_tag    - operation issue and owner tag
//   in_a, in_b         - Q16.16 operands
//   mid_valid          - stage-1 holds an operation (it completes next cycle)
//   out_valid/out_tag  - stage-2 result strobe and owner tag
//   out_data           - last product; held while out_valid is low
module mult_q16_pipe
  import fft_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  tag_t in_tag,
  input  q16_t in_a,
  input  q16_t in_b,
  output logic mid_valid,
  output logic out_valid,
  output tag_t out_tag,
  output q16_t out_data
);

  logic s1_valid;
  tag_t s1_tag;
  q16_t s1_a;
  q16_t s1_b;

  // Stage 1: capture the granted operands together with their owner tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_tag   <= in_tag;
      if (in_valid) begin
        s1_a <= in_a;
        s1_b <= in_b;
      end
    end
  end

  // Stage 2: register the product. The data register only loads when a real
  // operation arrives, so the result output holds between results.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_tag   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= s1_valid;
      out_tag   <= s1_tag;
      if (s1_valid) begin
        out_data <= q16_mul(s1_a, s1_b);
      end
    end
  end

  assign mid_valid = s1_valid;

endmodule

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Shares one pipelined Q16.16 multiplier among four requesters using a
// round-robin arbiter. Results come back two cycles after the grant, tagged
// with a one-hot strobe for the owning requester.
//   clk, rst   - clock, synchronous active-high reset
//   req_valid  - per-requester request
//   req_a/b    - packed Q16.16 operands, requester i at [32i+31:32i]
//   req_ready  - one-hot grant (combinational)
//   rsp_valid  - one-hot result strobe
//   rsp_data   - Q16.16 product
//   busy       - any multiplier stage holds an operation
//   op_count   - completed results, wraps at 16 bits
module mult_share_arbiter
  import fft_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy,
  output logic [15:0]               op_count
);

  tag_t rr_ptr;
  tag_t grant_idx;
  logic grant_any;
  logic issue;
  tag_t scan_idx;
  q16_t grant_a;
  q16_t grant_b;

  logic mid_valid;
  logic out_valid;
  tag_t out_tag;

  // Round-robin scan: starting at rr_ptr, the first requester found wins.
  // The 2-bit index wraps naturally, giving the modulo-4 walk.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = rr_ptr + tag_t'(k);
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  // Nothing is granted while reset is held, so no operation can enter the
  // pipe in a cycle whose state is about to be cleared.
  assign issue     = grant_any && !rst;
  assign req_ready = issue ? tag_to_onehot(grant_idx) : '0;
  assign grant_a   = req_a[DATA_W*int'(grant_idx) +: DATA_W];
  assign grant_b   = req_b[DATA_W*int'(grant_idx) +: DATA_W];

  // Pointer moves just past the winner; it stays put on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (issue) begin
      rr_ptr <= grant_idx + tag_t'(1);
    end
  end

  // Counted as stage 1 hands off, so the count already includes a result in
  // the same cycle its rsp_valid strobe is visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
    end else if (mid_valid) begin
      op_count <= op_count + 16'd1;
    end
  end

  mult_q16_pipe u_mult (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_tag    (grant_idx),
    .in_a      (grant_a),
    .in_b      (grant_b),
    .mid_valid (mid_valid),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (rsp_data)
  );

  assign rsp_valid = out_valid ? tag_to_onehot(out_tag) : '0;
  assign busy      = mid_valid | out_valid;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences, and a randomized phase, all compared every cycle against a
// queue-based reference model of the arbiter and multiplier.
module tb_mult_share_arbiter;
  import fft_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         busy;
  logic [15:0]  op_count;

  mult_share_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model state: outstanding results keyed by the cycle they are due
  typedef struct {
    int          due;
    int          tag;
    logic [31:0] data;
  } pend_t;

  pend_t       exp_q[$];
  int          m_ptr      = 0;
  int          m_count    = 0;
  logic [31:0] m_last     = '0;
  bit          known      = 1'b0;
  int          last_grant = -1;

  logic [31:0] opa[4];
  logic [31:0] opb[4];
  int          seen;

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  exp_valid;
    logic [31:0] exp_data;
    logic [15:0] exp_count;
  } vec_t;

  function automatic logic [31:0] refMul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> FRAC_W;
    return p[31:0];
  endfunction

  function automatic int refGrant(input logic [3:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [3:0] v);
    rst       = r;
    req_valid = v;
    req_a     = {opa[3], opa[2], opa[1], opa[0]};
    req_b     = {opb[3], opb[2], opb[1], opb[0]};
  endtask

  // Compare every output against the model at the falling edge, then advance
  // the model by what the coming rising edge will do.
  task automatic sampleCycle();
    int          g;
    logic [3:0]  exp_ready;
    logic [3:0]  exp_rv;
    logic [31:0] exp_d;
    logic        exp_busy;
    pend_t       p;
    @(negedge clk);
    g         = rst ? -1 : refGrant(req_valid, m_ptr);
    exp_ready = (g < 0) ? 4'b0000 : (4'b0001 << g);
    exp_busy  = 1'b0;
    foreach (exp_q[i]) if (exp_q[i].due <= cyc + 1) exp_busy = 1'b1;
    exp_rv = 4'b0000;
    exp_d  = m_last;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      p       = exp_q.pop_front();
      exp_rv  = 4'b0001 << p.tag;
      exp_d   = p.data;
      m_last  = p.data;
      m_count = (m_count + 1) & 16'hFFFF;
    end
    if (known) begin
      checkOutput("req_ready", {28'd0, req_ready}, {28'd0, exp_ready});
      checkOutput("rsp_valid", {28'd0, rsp_valid}, {28'd0, exp_rv});
      checkOutput("rsp_data", rsp_data, exp_d);
      checkOutput("busy", {31'd0, busy}, {31'd0, exp_busy});
      checkOutput("op_count", {16'd0, op_count}, m_count);
    end
    last_grant = -1;
    if (rst) begin
      exp_q.delete();
      m_ptr   = 0;
      m_count = 0;
      m_last  = '0;
      known   = 1'b1;
    end else if (g >= 0) begin
      p.due  = cyc + MULT_LAT;
      p.tag  = g;
      p.data = refMul(opa[g], opb[g]);
      exp_q.push_back(p);
      m_ptr      = (g + 1) % NUM_REQ;
      last_grant = g;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input logic [3:0] v);
    applyStimulus(1'b1, v);
    sampleCycle();
    nextCycle();
  endtask

  task automatic drain(input int n);
    applyStimulus(1'b0, 4'b0000);
    for (int i = 0; i < n; i++) begin
      sampleCycle();
      nextCycle();
    end
  endtask

  task automatic wrapWatch();
    if (rsp_valid != 4'b0000) begin
      seen++;
      if (seen == 65535) checkOutput("wrap_ffff", {16'd0, op_count}, 32'h0000FFFF);
      if (seen == 65536) checkOutput("wrap_zero", {16'd0, op_count}, 32'h00000000);
    end
  endtask

  vec_t tbl[6];

  initial begin
    logic [3:0] pend;
    logic [3:0] seq_exp;
    logic       rst_r;

    tbl[0] = '{0, 32'h00020000, 32'h00018000, 4'b0001, 32'h00030000, 16'd1};
    tbl[1] = '{3, 32'hFFFF0000, 32'h00028000, 4'b1000, 32'hFFFD8000, 16'd2};
    tbl[2] = '{1, 32'hFFFE0000, 32'hFFFD0000, 4'b0010, 32'h00060000, 16'd3};
    tbl[3] = '{2, 32'hFFFFFFFF, 32'h00008000, 4'b0100, 32'hFFFFFFFF, 16'd4};
    tbl[4] = '{1, 32'h7FFF0000, 32'h00020000, 4'b0010, 32'hFFFE0000, 16'd5};
    tbl[5] = '{0, 32'h00010000, 32'h12345678, 4'b0001, 32'h12345678, 16'd6};

    for (int i = 0; i < 4; i++) begin
      opa[i] = '0;
      opb[i] = '0;
    end
    applyStimulus(1'b1, 4'b0000);
    doReset(4'b0000);
    doReset(4'b0000);

    // Directed single-requester vectors, result checked two cycles after grant
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        opa[i] = '0;
        opb[i] = '0;
      end
      opa[tbl[v].idx] = tbl[v].a;
      opb[tbl[v].idx] = tbl[v].b;
      applyStimulus(1'b0, 4'b0001 << tbl[v].idx);
      sampleCycle();
      checkOutput("tbl_grant", {28'd0, req_ready}, {28'd0, tbl[v].exp_valid});
      nextCycle();
      applyStimulus(1'b0, 4'b0000);
      sampleCycle();
      nextCycle();
      sampleCycle();
      checkOutput("tbl_rsp_valid", {28'd0, rsp_valid}, {28'd0, tbl[v].exp_valid});
      checkOutput("tbl_rsp_data", rsp_data, tbl[v].exp_data);
      checkOutput("tbl_op_count", {16'd0, op_count}, {16'd0, tbl[v].exp_count});
      nextCycle();
    end
    drain(2);

    // All four requesting straight out of reset
    for (int i = 0; i < 4; i++) begin
      opa[i] = 32'h00010000 * (i + 1);
      opb[i] = 32'h00008000;
    end
    doReset(4'b1111);
    applyStimulus(1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      sampleCycle();
      seq_exp = 4'b0001 << (i % 4);
      checkOutput("rr_grant_seq", {28'd0, req_ready}, {28'd0, seq_exp});
      if (i >= 2) begin
        seq_exp = 4'b0001 << ((i - 2) % 4);
        checkOutput("rr_rsp_seq", {28'd0, rsp_valid}, {28'd0, seq_exp});
      end
      nextCycle();
    end
    drain(3);

    // Pointer parked at 2, requesters 2 and 0 contend
    doReset(4'b0000);
    applyStimulus(1'b0, 4'b0010);
    sampleCycle();
    checkOutput("ptr_setup", {28'd0, req_ready}, 32'h2);
    nextCycle();
    applyStimulus(1'b0, 4'b0101);
    sampleCycle();
    checkOutput("ptr2_first", {28'd0, req_ready}, 32'h4);
    nextCycle();
    applyStimulus(1'b0, 4'b0001);
    sampleCycle();
    checkOutput("ptr2_second", {28'd0, req_ready}, 32'h1);
    nextCycle();
    drain(3);

    // Reset lands one cycle after a grant: the operation must vanish
    doReset(4'b0000);
    applyStimulus(1'b0, 4'b0010);
    sampleCycle();
    checkOutput("rst_pre_grant", {28'd0, req_ready}, 32'h2);
    nextCycle();
    applyStimulus(1'b1, 4'b0010);
    sampleCycle();
    checkOutput("rst_ready", {28'd0, req_ready}, 32'h0);
    nextCycle();
    applyStimulus(1'b0, 4'b1111);
    sampleCycle();
    checkOutput("rst_rsp_valid", {28'd0, rsp_valid}, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'h0);
    checkOutput("rst_grant0", {28'd0, req_ready}, 32'h1);
    nextCycle();
    drain(3);

    // Randomized traffic; requesters hold until granted, occasional reset
    pend = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      rst_r = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < 4; i++) begin
        if (last_grant == i) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = $urandom;
          opb[i]  = $urandom;
        end
      end
      applyStimulus(rst_r, pend);
      sampleCycle();
      nextCycle();
    end
    drain(3);

    // Counter wrap: 65536 back-to-back operations
    doReset(4'b0000);
    seen = 0;
    for (int n = 0; n < 65536; n++) begin
      if (last_grant >= 0) begin
        opa[last_grant] = $urandom;
        opb[last_grant] = $urandom;
      end
      applyStimulus(1'b0, 4'b1111);
      sampleCycle();
      wrapWatch();
      nextCycle();
    end
    applyStimulus(1'b0, 4'b0000);
    for (int n = 0; n < 4; n++) begin
      sampleCycle();
      wrapWatch();
      nextCycle();
    end
    checkOutput("wrap_results", seen, 32'd65536);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
